// File: rtl/rcpu_mem_responder.sv
// RCPU memory-side responder: program/data RAM with host boot-load port,
// a byte output FIFO at IO_ADDR and a status word at STAT_ADDR.
module rcpu_mem_responder #(
  parameter int unsigned    M         = 16,
  parameter int unsigned    AW        = 8,
  parameter int unsigned    FIFO_LOG2 = 2,
  parameter logic [M-1:0]   IO_ADDR   = {M{1'b1}},
  parameter logic [M-1:0]   STAT_ADDR = {{(M-1){1'b1}}, 1'b0}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] memAddr,
  input  logic [M-1:0] memWrite,
  input  logic         memWE,
  output logic [M-1:0] memRead,
  output logic         cpu_rst,
  input  logic         load_valid,
  input  logic [M-1:0] load_data,
  output logic         load_ready,
  input  logic         load_done,
  output logic         out_valid,
  output logic [7:0]   out_data,
  input  logic         out_ready
);

  localparam int unsigned RAM_WORDS  = 2 ** AW;
  localparam int unsigned FIFO_DEPTH = 2 ** FIFO_LOG2;
  localparam int unsigned CW         = FIFO_LOG2 + 1;

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [AW-1:0]        load_ptr_q, load_ptr_d;
  logic                 load_full_q, load_full_d;
  logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 drop_q, drop_d;

  logic [M-1:0]         ram_q  [RAM_WORDS];
  logic [7:0]           fifo_q [FIFO_DEPTH];

  logic run;
  logic is_io;
  logic is_stat;
  logic load_acc;
  logic cpu_we;
  logic push_req;
  logic push;
  logic pop;
  logic stat_wr;
  logic ram_cpu_we;
  logic fifo_full;
  logic fifo_empty;

  // Address decode and handshake qualifiers
  always_comb begin
    run        = (state_q == ST_RUN);
    is_io      = (memAddr == IO_ADDR);
    is_stat    = (memAddr == STAT_ADDR);
    load_acc   = !run && load_valid && !load_full_q;
    cpu_we     = run && memWE;
    push_req   = cpu_we && is_io;
    stat_wr    = cpu_we && !is_io && is_stat;
    ram_cpu_we = cpu_we && !is_io && !is_stat;
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    fifo_empty = (count_q == '0);
    pop        = !fifo_empty && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    push       = push_req && (!fifo_full || pop);
  end

  // Load/run sequencing next state
  always_comb begin
    state_d     = state_q;
    load_ptr_d  = load_ptr_q;
    load_full_d = load_full_q;
    if (state_q == ST_LOAD) begin
      if (load_acc) begin
        load_ptr_d = load_ptr_q + AW'(1);
        if (load_ptr_q == AW'(RAM_WORDS - 1)) begin
          load_full_d = 1'b1;
        end
      end
      if (load_done) begin
        state_d = ST_RUN;
      end
    end
  end

  // Output FIFO pointers, occupancy and sticky drop flag next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + FIFO_LOG2'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + FIFO_LOG2'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    if (push_req && !push) begin
      drop_d = 1'b1;
    end else if (stat_wr) begin
      drop_d = 1'b0;
    end
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_LOAD;
      load_ptr_q  <= '0;
      load_full_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_ptr_q  <= load_ptr_d;
      load_full_q <= load_full_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      drop_q      <= drop_d;
    end
  end

  // RAM write port: host loader while loading, CPU while running; contents survive reset
  always_ff @(posedge clk) begin
    if (rst) begin
      if (load_acc) begin
        ram_q[load_ptr_q] <= load_data;
      end else if (ram_cpu_we) begin
        ram_q[memAddr[AW-1:0]] <= memWrite;
      end
    end
  end

  // FIFO byte storage
  always_ff @(posedge clk) begin
    if (rst && push) begin
      fifo_q[wr_ptr_q] <= memWrite[7:0];
    end
  end

  // Same-cycle read decode, IO word has priority over status over RAM
  always_comb begin
    memRead = '0;
    if (run) begin
      if (is_io) begin
        memRead = '0;
      end else if (is_stat) begin
        memRead = M'({drop_q, fifo_full, !fifo_empty});
      end else begin
        memRead = ram_q[memAddr[AW-1:0]];
      end
    end
  end

  // Status outputs derived directly from registered state
  assign cpu_rst    = run;
  assign load_ready = !run && !load_full_q;
  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_rcpu_mem_responder.sv
// Self-checking bench for rcpu_mem_responder: boot load, RAM access,
// output FIFO with drop/status handling, and mid-run reset.
module tb_rcpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] memAddr;
  logic [15:0] memWrite;
  logic        memWE;
  logic [15:0] memRead;
  logic        cpu_rst;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic        load_done;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] ram_m [256];
  logic [7:0]  exp_q [$];
  logic [7:0]  exp_b;

  rcpu_mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .memAddr    (memAddr),
    .memWrite   (memWrite),
    .memWE      (memWE),
    .memRead    (memRead),
    .cpu_rst    (cpu_rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge; inputs are driven and outputs sampled mid-low-phase
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    load_valid = 1'b0; load_done = 1'b0; memWE = 1'b0; out_ready = 1'b0;
    cyc();
    rst = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    memAddr = 16'h0001; memWrite = '0; load_data = '0;
    cyc();
    do_reset();
    #1;
    n_checks++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_rst: got %b want 0", cpu_rst); end
    n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL rst_load_ready: got %b want 1", load_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_checks++; if (memRead !== 16'h0000) begin n_fail++; $display("FAIL rst_memRead: got %h want 0000", memRead); end
  endtask

  task automatic test_load_basic();
    load_valid = 1'b1; load_data = 16'h1234;
    cyc(); ram_m[0] = 16'h1234;
    load_data = 16'hABCD; load_done = 1'b1;
    #1;
    n_checks++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL ld_cpu_rst_pre: got %b want 0", cpu_rst); end
    cyc(); ram_m[1] = 16'hABCD;
    load_valid = 1'b0; load_done = 1'b0;
    #1;
    n_checks++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL ld_cpu_rst_post: got %b want 1", cpu_rst); end
    n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL ld_ready_run: got %b want 0", load_ready); end
    memAddr = 16'h0000; #1;
    n_checks++; if (memRead !== 16'h1234) begin n_fail++; $display("FAIL ld_rd0: got %h want 1234", memRead); end
    memAddr = 16'h0001; #1;
    n_checks++; if (memRead !== 16'hABCD) begin n_fail++; $display("FAIL ld_rd1: got %h want abcd", memRead); end
  endtask

  task automatic test_load_full();
    logic [15:0] w;
    do_reset();
    memAddr = 16'h0000;
    for (int i = 0; i < 256; i++) begin
      w = 16'(i) ^ 16'hA5C3;
      load_valid = 1'b1; load_data = w;
      if (i == 255) begin
        #1;
        n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_last: got %b want 1", load_ready); end
      end
      cyc();
      ram_m[i] = w;
    end
    #1;
    n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_after: got %b want 0", load_ready); end
    n_checks++; if (memRead !== 16'h0000) begin n_fail++; $display("FAIL full_memRead_load: got %h want 0000", memRead); end
    load_data = 16'hDEAD; memWE = 1'b1; memWrite = 16'hBEEF;
    cyc(); cyc();
    load_valid = 1'b0; memWE = 1'b0;
    load_done = 1'b1;
    cyc();
    load_done = 1'b0;
    memAddr = 16'h0000; #1;
    n_checks++; if (memRead !== ram_m[0]) begin n_fail++; $display("FAIL full_rd0: got %h want %h", memRead, ram_m[0]); end
    memAddr = 16'h00FF; #1;
    n_checks++; if (memRead !== ram_m[255]) begin n_fail++; $display("FAIL full_rd255: got %h want %h", memRead, ram_m[255]); end
    memAddr = 16'h0080; #1;
    n_checks++; if (memRead !== ram_m[128]) begin n_fail++; $display("FAIL full_rd128: got %h want %h", memRead, ram_m[128]); end
  endtask

  task automatic test_ram_rw();
    memAddr = 16'h0010; memWrite = 16'h0055; memWE = 1'b1; #1;
    n_checks++; if (memRead !== ram_m[8'h10]) begin n_fail++; $display("FAIL rw_old: got %h want %h", memRead, ram_m[8'h10]); end
    cyc();
    ram_m[8'h10] = 16'h0055;
    memWE = 1'b0; #1;
    n_checks++; if (memRead !== 16'h0055) begin n_fail++; $display("FAIL rw_new: got %h want 0055", memRead); end
    memAddr = 16'h0110; #1;
    n_checks++; if (memRead !== 16'h0055) begin n_fail++; $display("FAIL rw_alias: got %h want 0055", memRead); end
    memAddr = 16'hFFFF; #1;
    n_checks++; if (memRead !== 16'h0000) begin n_fail++; $display("FAIL rw_io_read: got %h want 0000", memRead); end
  endtask

  task automatic test_fifo();
    logic [7:0] msg [4];
    msg[0] = 8'h41; msg[1] = 8'h42; msg[2] = 8'h43; msg[3] = 8'h44;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      memAddr = 16'hFFFF; memWrite = {8'h7E, msg[i]}; memWE = 1'b1;
      exp_q.push_back(msg[i]);
      cyc();
    end
    memWE = 1'b0; memAddr = 16'hFFFE; #1;
    n_checks++; if (memRead !== 16'h0003) begin n_fail++; $display("FAIL fifo_stat_full: got %h want 0003", memRead); end
    memAddr = 16'hFFFF; memWrite = 16'h0045; memWE = 1'b1;
    cyc();
    memWE = 1'b0; memAddr = 16'hFFFE; #1;
    n_checks++; if (memRead !== 16'h0007) begin n_fail++; $display("FAIL fifo_stat_drop: got %h want 0007", memRead); end
    out_ready = 1'b1;
    for (int k = 0; k < 8 && exp_q.size() != 0; k++) begin
      exp_b = exp_q.pop_front();
      #1;
      n_checks++; if (out_valid !== 1'b1 || out_data !== exp_b) begin n_fail++; $display("FAIL fifo_drain: got valid=%b data=%h want %h", out_valid, out_data, exp_b); end
      cyc();
    end
    out_ready = 1'b0; #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fifo_empty: got valid=%b want 0", out_valid); end
    n_checks++; if (memRead !== 16'h0004) begin n_fail++; $display("FAIL fifo_stat_droponly: got %h want 0004", memRead); end
    memWE = 1'b1; memWrite = 16'h1234;
    cyc();
    memWE = 1'b0; #1;
    n_checks++; if (memRead !== 16'h0000) begin n_fail++; $display("FAIL fifo_stat_clear: got %h want 0000", memRead); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      memAddr = 16'hFFFF; memWrite = 16'h0011 + 16'(i); memWE = 1'b1;
      exp_q.push_back(8'h11 + 8'(i));
      cyc();
    end
    memWrite = 16'h0058; out_ready = 1'b1;
    exp_b = exp_q.pop_front();
    exp_q.push_back(8'h58);
    #1;
    n_checks++; if (out_data !== exp_b) begin n_fail++; $display("FAIL b2b_head: got %h want %h", out_data, exp_b); end
    cyc();
    memWE = 1'b0; out_ready = 1'b0; memAddr = 16'hFFFE; #1;
    n_checks++; if (memRead !== 16'h0003) begin n_fail++; $display("FAIL b2b_stat: got %h want 0003", memRead); end
    out_ready = 1'b1;
    for (int k = 0; k < 8 && exp_q.size() != 0; k++) begin
      exp_b = exp_q.pop_front();
      #1;
      n_checks++; if (out_valid !== 1'b1 || out_data !== exp_b) begin n_fail++; $display("FAIL b2b_drain: got valid=%b data=%h want %h", out_valid, out_data, exp_b); end
      cyc();
    end
    out_ready = 1'b0; #1;
    n_checks++; if (memRead !== 16'h0000) begin n_fail++; $display("FAIL b2b_stat_end: got %h want 0000", memRead); end
  endtask

  task automatic test_reset_mid_run();
    out_ready = 1'b0;
    memAddr = 16'hFFFF; memWrite = 16'h0021; memWE = 1'b1;
    cyc();
    memWrite = 16'h0022;
    cyc();
    memWE = 1'b0; #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
    memAddr = 16'hFFFE;
    rst = 1'b0;
    cyc();
    rst = 1'b1; exp_q.delete(); #1;
    n_checks++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL mid_cpu_rst: got %b want 0", cpu_rst); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL mid_load_ready: got %b want 1", load_ready); end
    n_checks++; if (memRead !== 16'h0000) begin n_fail++; $display("FAIL mid_memRead: got %h want 0000", memRead); end
    load_done = 1'b1;
    cyc();
    load_done = 1'b0;
    memAddr = 16'h0010; #1;
    n_checks++; if (memRead !== ram_m[8'h10]) begin n_fail++; $display("FAIL mid_ram_kept: got %h want %h", memRead, ram_m[8'h10]); end
    memAddr = 16'hFFFE; #1;
    n_checks++; if (memRead !== 16'h0000) begin n_fail++; $display("FAIL mid_stat: got %h want 0000", memRead); end
  endtask

  initial begin
    rst = 1'b0; memAddr = '0; memWrite = '0; memWE = 1'b0;
    load_valid = 1'b0; load_data = '0; load_done = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 256; i++) ram_m[i] = 16'h0000;
    test_reset();
    test_load_basic();
    test_load_full();
    test_ram_rw();
    test_fifo();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
